// File: rtl/pc_gen.sv
// pc_gen: program counter generator. Holds the fetch address and presents it
// to instruction fetch over a valid/ready handshake. The next PC is chosen by
// fixed priority: exception, eret, redirect, then sequential advance.
// EPC and the last misaligned redirect target are captured here.
module pc_gen #(
  parameter int          AW         = 32,
  parameter logic [31:0] RESET_VEC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
  parameter int          INC        = 4,
  parameter int          ALIGN_BITS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pcwr,
  input  logic          fetch_ready,
  input  logic          redir_vld,
  input  logic [AW-1:0] redir_tgt,
  input  logic          exc_req,
  input  logic [AW-1:0] exc_pc,
  input  logic          eret,
  input  logic          halt_req,
  input  logic          resume,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus,
  output logic          fetch_valid,
  output logic [AW-1:0] epc,
  output logic [AW-1:0] badaddr,
  output logic          exc_taken
);

  localparam logic [AW-1:0] RV         = AW'(RESET_VEC);
  localparam logic [AW-1:0] EV         = AW'(EXC_VEC);
  localparam logic [AW-1:0] STEP       = AW'(INC);
  // Low-bit mask for the alignment check; a mask avoids a zero-width
  // part-select when ALIGN_BITS is 0.
  localparam logic [AW-1:0] ALIGN_MASK = AW'((64'd1 << ALIGN_BITS) - 64'd1);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_epc;
  logic [AW-1:0] r_badaddr;
  logic          r_exc_taken;
  logic [AW-1:0] w_pc_plus;
  logic          w_misalign;

  assign w_pc_plus  = r_pc + STEP;
  assign w_misalign = |(redir_tgt & ALIGN_MASK);

  assign pc          = r_pc;
  assign pc_plus     = w_pc_plus;
  assign fetch_valid = (r_state == S_RUN);
  assign epc         = r_epc;
  assign badaddr     = r_badaddr;
  assign exc_taken   = r_exc_taken;

  // Next-PC select and control state; exc_req bypasses the pcwr stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_BOOT;
      r_pc        <= RV;
      r_epc       <= '0;
      r_badaddr   <= '0;
      r_exc_taken <= 1'b0;
    end else begin
      r_exc_taken <= 1'b0;
      if (exc_req) begin
        // Exception beats any same-cycle eret/redirect and wakes from HALT.
        r_pc        <= EV;
        r_epc       <= exc_pc;
        r_exc_taken <= 1'b1;
        r_state     <= S_RUN;
      end else if (!pcwr) begin
        // Stall: PC and state hold, but BOOT is never held past one edge.
        if (r_state == S_BOOT) r_state <= S_RUN;
      end else if (eret) begin
        r_pc    <= r_epc;
        r_state <= S_RUN;
      end else if (redir_vld) begin
        // Redirect drops any pending fetch; a misaligned target traps.
        if (w_misalign) begin
          r_pc        <= EV;
          r_epc       <= r_pc;
          r_badaddr   <= redir_tgt;
          r_exc_taken <= 1'b1;
        end else begin
          r_pc <= redir_tgt;
        end
        if (r_state == S_BOOT) r_state <= S_RUN;
      end else begin
        case (r_state)
          S_BOOT: r_state <= S_RUN;
          S_RUN: begin
            // An accepted fetch always advances, even on the halting edge,
            // so the same address is not fetched twice.
            if (fetch_ready) r_pc <= w_pc_plus;
            if (halt_req) r_state <= S_HALT;
          end
          S_HALT: if (resume) r_state <= S_RUN;
          default: r_state <= S_BOOT;
        endcase
      end
    end
  end

endmodule
